// File: rtl/atomicity_multi.sv
// atomicity_multi: PC-trace monitor that kills the platform on illegal entry/exit/irq in protected regions
module atomicity_multi #(
    parameter int NREG = 2,
    parameter int NENT = 1,
    parameter logic [16*NREG-1:0] REG_BASE = {16'hA000, 16'hE000},
    parameter logic [16*NREG-1:0] REG_LAST = {16'hA7FE, 16'hEFFE},
    parameter logic [16*NREG*(NENT > 0 ? NENT : 1)-1:0] REG_ENTRY = {16'hA100, 16'hE400},
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter bit IRQ_KILL = 1'b1,
    parameter bit ALLOW_REENTRY = 1'b0,
    parameter int RW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   pc,
    input  logic          pc_en,
    input  logic          irq,
    output logic          reset,
    output logic          in_atomic,
    output logic [RW-1:0] active_region,
    output logic [1:0]    viol_cause
);
    typedef enum logic [2:0] {OUT, FIRST, MID, LAST, KILL} state_t;
    state_t state, nxt;
    logic [RW-1:0] cur, nxt_cur, idx;
    logic [NREG-1:0] hit_in, hit_ent, hit_last;
    logic [1:0] nxt_cause;
    logic any_in, in_c, ent_c, last_c;
    // Per-region address decode; regions are disjoint so at most one hit_in bit is set
    always_comb begin
        hit_in = '0;
        hit_ent = '0;
        hit_last = '0;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            hit_in[i] = pc >= REG_BASE[16*i+:16] && pc <= REG_LAST[16*i+:16];
            hit_ent[i] = pc == REG_BASE[16*i+:16];
            for (int j = 0; j < NENT; j++)
                hit_ent[i] = hit_ent[i] | (pc == REG_ENTRY[16*(i*NENT+j)+:16]);
            hit_last[i] = pc == REG_LAST[16*i+:16];
            if (hit_in[i]) idx = RW'(i);
        end
        any_in = |hit_in;
        in_c = hit_in[cur];
        ent_c = hit_ent[cur];
        last_c = hit_last[cur];
    end
    // Next-state logic; nxt_cause is only used on the transition into KILL
    always_comb begin
        nxt = state;
        nxt_cur = cur;
        nxt_cause = 2'b00;
        if (pc_en) begin
            case (state)
                OUT:
                    if (any_in && hit_ent[idx]) begin
                        nxt = FIRST;
                        nxt_cur = idx;
                    end else if (any_in) begin
                        nxt = KILL;
                        nxt_cause = 2'b01;
                    end
                FIRST, MID:
                    if (irq && IRQ_KILL) begin
                        nxt = KILL;
                        nxt_cause = 2'b11;
                    end else if (!in_c) begin
                        nxt = KILL;
                        nxt_cause = 2'b10;
                    end else if (last_c) nxt = LAST;
                    else if (state == MID && ent_c && !ALLOW_REENTRY) begin
                        nxt = KILL;
                        nxt_cause = 2'b01;
                    end else nxt = (state == FIRST && ent_c) ? FIRST : MID;
                LAST:
                    if (last_c) nxt = LAST;
                    else if (!any_in) nxt = OUT;
                    else if (idx != cur && hit_ent[idx]) begin
                        nxt = FIRST;
                        nxt_cur = idx;
                    end else begin
                        nxt = KILL;
                        nxt_cause = (idx != cur) ? 2'b01 : 2'b10;
                    end
                KILL: nxt = (pc == RESET_HANDLER) ? OUT : KILL;
                default: nxt = KILL;
            endcase
        end
    end
    // State and output registers; power-up lands in KILL so the handler must run first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= KILL;
            cur <= '0;
            reset <= 1'b1;
            in_atomic <= 1'b0;
            viol_cause <= 2'b00;
        end else begin
            state <= nxt;
            cur <= nxt_cur;
            reset <= nxt == KILL;
            in_atomic <= nxt == FIRST || nxt == MID || nxt == LAST;
            if (nxt == KILL && state != KILL) viol_cause <= nxt_cause;
        end
    end
    assign active_region = cur;
endmodule

// File: tb/tb_atomicity_multi.sv
// tb_atomicity_multi: scoreboard bench for the atomicity monitor
module tb_atomicity_multi;
    logic clk = 1'b0, reset_n, reset_n2, pc_en, irq;
    logic [15:0] pc;
    logic reset, in_atomic, reset2, in_atomic2;
    logic [0:0] active_region, active_region2;
    logic [1:0] viol_cause, viol_cause2;
    int checks = 0, errors = 0;

    typedef struct {
        string nm;
        logic r, a, g;
        logic [1:0] c;
        bit k2;
        logic r2, a2;
    } exp_t;
    exp_t q[$];
    exp_t e;

    atomicity_multi dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .pc_en(pc_en), .irq(irq),
        .reset(reset), .in_atomic(in_atomic), .active_region(active_region), .viol_cause(viol_cause)
    );
    atomicity_multi #(.IRQ_KILL(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n2), .pc(pc), .pc_en(pc_en), .irq(irq),
        .reset(reset2), .in_atomic(in_atomic2), .active_region(active_region2), .viol_cause(viol_cause2)
    );

    always #5 clk = ~clk;

    // Monitor: after every edge, compare the DUT against the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (reset !== e.r || in_atomic !== e.a || active_region !== e.g || viol_cause !== e.c) begin
                errors++;
                $display("FAIL %s: got reset=%0b in_atomic=%0b region=%0d cause=%0d, want reset=%0b in_atomic=%0b region=%0d cause=%0d",
                         e.nm, reset, in_atomic, active_region, viol_cause, e.r, e.a, e.g, e.c);
            end
            if (e.k2) begin
                checks++;
                if (reset2 !== e.r2 || in_atomic2 !== e.a2) begin
                    errors++;
                    $display("FAIL %s(irq_kill=0): got reset=%0b in_atomic=%0b, want reset=%0b in_atomic=%0b",
                             e.nm, reset2, in_atomic2, e.r2, e.a2);
                end
            end
        end
    end

    task automatic step(input string nm, input logic [15:0] p, input logic en, input logic ir,
                        input logic r, input logic a, input logic g, input logic [1:0] c,
                        input bit k2 = 1'b0, input logic r2 = 1'b0, input logic a2 = 1'b0);
        exp_t x;
        @(negedge clk);
        pc = p;
        pc_en = en;
        irq = ir;
        x.nm = nm; x.r = r; x.a = a; x.g = g; x.c = c; x.k2 = k2; x.r2 = r2; x.a2 = a2;
        q.push_back(x);
    endtask

    task automatic chk_now(input string nm, input logic r, input logic a, input logic g, input logic [1:0] c);
        checks++;
        if (reset !== r || in_atomic !== a || active_region !== g || viol_cause !== c) begin
            errors++;
            $display("FAIL %s: got reset=%0b in_atomic=%0b region=%0d cause=%0d, want reset=%0b in_atomic=%0b region=%0d cause=%0d",
                     nm, reset, in_atomic, active_region, viol_cause, r, a, g, c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0; pc = 16'h0; pc_en = 1'b0; irq = 1'b0;
        #12;
        chk_now("por", 1'b1, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        // T1: legal pass through region 0
        step("t1_handler", 16'hFFFE, 1, 0, 0, 0, 0, 2'd0);
        step("t1_out",     16'h4000, 1, 0, 0, 0, 0, 2'd0);
        step("t1_base",    16'hE000, 1, 0, 0, 1, 0, 2'd0);
        step("t1_mid",     16'hE002, 1, 0, 0, 1, 0, 2'd0);
        step("t1_last",    16'hEFFE, 1, 0, 0, 1, 0, 2'd0);
        step("t1_exit",    16'h4000, 1, 0, 0, 0, 0, 2'd0);
        // T2: interior entry
        step("t2_interior", 16'hE010, 1, 0, 1, 0, 0, 2'd1);
        step("t2_hold",     16'h4000, 1, 0, 1, 0, 0, 2'd1);
        step("t2_release",  16'hFFFE, 1, 0, 0, 0, 0, 2'd1);
        // T3: early exit from region 1
        step("t3_entry",  16'hA100, 1, 0, 0, 1, 1, 2'd1);
        step("t3_mid",    16'hA102, 1, 0, 0, 1, 1, 2'd1);
        step("t3_escape", 16'h5000, 1, 0, 1, 0, 1, 2'd2);
        step("t3_release", 16'hFFFE, 1, 0, 0, 0, 1, 2'd2);
        // T4: irq inside region, second instance ignores irq
        reset_n2 = 1'b1;
        step("t4_out",   16'hFFFE, 1, 0, 0, 0, 1, 2'd2, 1, 0, 0);
        step("t4_base",  16'hE000, 1, 0, 0, 1, 0, 2'd2, 1, 0, 1);
        step("t4_irq",   16'hE002, 1, 1, 1, 0, 0, 2'd3, 1, 0, 1);
        step("t4_irq2",  16'hE004, 1, 1, 1, 0, 0, 2'd3, 1, 0, 1);
        step("t4_release", 16'hFFFE, 1, 0, 0, 0, 0, 2'd3);
        // T5: chained regions and forbidden re-entry
        step("t5_base",   16'hE000, 1, 0, 0, 1, 0, 2'd3);
        step("t5_last",   16'hEFFE, 1, 0, 0, 1, 0, 2'd3);
        step("t5_chain",  16'hA000, 1, 0, 0, 1, 1, 2'd3);
        step("t5_last1",  16'hA7FE, 1, 0, 0, 1, 1, 2'd3);
        step("t5_exit",   16'h6000, 1, 0, 0, 0, 1, 2'd3);
        step("t5_base2",  16'hE000, 1, 0, 0, 1, 0, 2'd3);
        step("t5_mid",    16'hE002, 1, 0, 0, 1, 0, 2'd3);
        step("t5_reentry", 16'hE400, 1, 0, 1, 0, 0, 2'd1);
        step("t5_release", 16'hFFFE, 1, 0, 0, 0, 0, 2'd1);
        // T6: pc_en gating, back-jump from LAST, entry dwell in FIRST
        step("t6_base",   16'hE000, 1, 0, 0, 1, 0, 2'd1);
        step("t6_gate1",  16'h5000, 0, 0, 0, 1, 0, 2'd1);
        step("t6_gate2",  16'hA7FE, 0, 1, 0, 1, 0, 2'd1);
        step("t6_mid",    16'hE002, 1, 0, 0, 1, 0, 2'd1);
        step("t6_last",   16'hEFFE, 1, 0, 0, 1, 0, 2'd1);
        step("t6_backjump", 16'hE002, 1, 0, 1, 0, 0, 2'd2);
        step("t6_release", 16'hFFFE, 1, 0, 0, 0, 0, 2'd2);
        step("t6_base2",  16'hE000, 1, 0, 0, 1, 0, 2'd2);
        step("t6_ent1",   16'hE400, 1, 0, 0, 1, 0, 2'd2);
        step("t6_ent2",   16'hE400, 1, 0, 0, 1, 0, 2'd2);
        step("t6_mid2",   16'hE402, 1, 0, 0, 1, 0, 2'd2);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_now("async_reset", 1'b1, 1'b0, 1'b0, 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
